// File: rtl/mem_arb_pkg.sv
// Shared types and default constants for the unified instruction/data memory arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF         = 32;
    localparam int unsigned DATA_W_DEF         = 32;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } arb_state_e;

endpackage

// File: rtl/arb_watchdog.sv
// Counts consecutive stalled BUSY cycles; flags expiry in the cycle the count reaches the limit.
module arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic busy,
    input  logic ready,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;

    // cnt_q holds the stalled cycles before this one, so expiry fires on the Nth stalled cycle
    assign expired = busy & ~ready & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (~busy | ready | expired) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Fixed-priority (data over fetch) arbiter onto one hold-until-ready memory port.
// Optional watchdog abort is enabled by defining ARB_TIMEOUT_EN.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W         = ADDR_W_DEF,
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_kill,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_done,
    input  logic                dm_read,
    input  logic                dm_write,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_wstrb,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_done,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ready,
    output logic                stall_f,
    output logic                stall_m,
    output logic                bus_err
);

    arb_state_e          state_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [DATA_W/8-1:0] mem_wstrb_q;
    logic                kill_q;
    logic                expired;
    logic                busy;
    logic                finish;

    assign busy   = (state_q != IDLE);
    assign finish = busy & (mem_ready | expired);

`ifdef ARB_TIMEOUT_EN
    arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .busy   (busy),
        .ready  (mem_ready),
        .expired(expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
    assign expired        = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            kill_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    kill_q <= 1'b0;
                    if (dm_read | dm_write) begin
                        state_q     <= DM_BUSY;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= dm_write;
                        mem_addr_q  <= dm_addr;
                        mem_wdata_q <= dm_write ? dm_wdata : '0;
                        mem_wstrb_q <= dm_write ? dm_wstrb : '0;
                    end else if (if_req & ~if_kill) begin
                        state_q     <= IF_BUSY;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr;
                        mem_wdata_q <= '0;
                        mem_wstrb_q <= '0;
                    end
                end
                IF_BUSY, DM_BUSY: begin
                    // a killed fetch still runs to completion on the backend
                    if (finish) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        kill_q    <= 1'b0;
                    end else if ((state_q == IF_BUSY) & if_kill) begin
                        kill_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                    kill_q    <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

    assign dm_done  = (state_q == DM_BUSY) & (mem_ready | expired);
    assign if_done  = (state_q == IF_BUSY) & ((mem_ready & ~kill_q & ~if_kill) | expired);
    assign bus_err  = expired;
    assign if_rdata = (if_done & ~expired) ? mem_rdata : '0;
    assign dm_rdata = (dm_done & ~expired) ? mem_rdata : '0;

    assign stall_f = if_req & ~if_done;
    assign stall_m = (dm_read | dm_write) & ~dm_done;

endmodule
